// File: rtl/seq_div8x4_pkg.sv
// Shared arithmetic package.
// Holds the default operand widths for the sequential divider and the
// companion multiplier, the divider FSM state encoding, and a small helper
// that sizes the step counter.
package seq_div8x4_pkg;

  // Divider defaults: dividend/quotient width and divisor/remainder width.
  localparam int DIV_DW_N = 8;
  localparam int DIV_DW_D = 4;

  // Multiplier defaults (the 8x4 multiplier that sits next to the divider).
  localparam int MUL_DW_A = 8;
  localparam int MUL_DW_B = 4;
  localparam int MUL_DW_P = MUL_DW_A + MUL_DW_B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // The step counter must hold DW_N-1; keep it at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_div8x4_div_step.sv
// div_step: one restoring-division step, purely combinational.
// Ports:
//   rem_in   - current partial remainder (DW_D+1 bits, always < divisor)
//   bit_in   - next dividend bit, shifted in at the LSB
//   divisor  - unsigned divisor
//   rem_out  - partial remainder after the step
//   q_bit    - quotient bit produced by the step
module div_step #(
  parameter int DW_D = 4
) (
  input  logic [DW_D:0]   rem_in,
  input  logic            bit_in,
  input  logic [DW_D-1:0] divisor,
  output logic [DW_D:0]   rem_out,
  output logic            q_bit
);

  logic [DW_D+1:0] shifted;
  logic [DW_D+1:0] diff;

  // rem_in < divisor keeps the shifted value below 2*divisor, so one extra
  // bit above the partial remainder is enough to serve as the sign.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[DW_D+1];
    rem_out = q_bit ? diff[DW_D:0] : shifted[DW_D:0];
  end

endmodule

// File: rtl/seq_div8x4.sv
// seq_div8x4: sequential unsigned restoring divider, one quotient bit per
// clock cycle.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - begin a division (only looked at while idle)
//   dividend     - DW_N-bit numerator, captured on acceptance
//   divisor      - DW_D-bit denominator, captured on acceptance
//   quotient     - registered quotient, updated when a result completes
//   remainder    - registered remainder, updated when a result completes
//   busy         - high while the division steps are running
//   done         - one-cycle pulse, results valid
//   div_by_zero  - set by a zero divisor, held with the results
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one restoring step per cycle, DW_N cycles
// DONE    | done pulse, results on the outputs
module seq_div8x4
  import seq_div8x4_pkg::*;
#(
  parameter int DW_N = DIV_DW_N,
  parameter int DW_D = DIV_DW_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(DW_N);

  div_state_t      state;
  logic [DW_N-1:0] dvd_sr;
  logic [DW_N-1:0] quo_sr;
  logic [DW_D-1:0] dvs;
  logic [DW_D:0]   prem;
  logic [CW-1:0]   cnt;

  logic [DW_D:0]   step_rem;
  logic            step_q;

  div_step #(.DW_D(DW_D)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_sr[DW_N-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dvd_sr      <= '0;
      quo_sr      <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor skips the steps and reports saturated results.
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              dvd_sr <= dividend;
              dvs    <= divisor;
              quo_sr <= '0;
              prem   <= '0;
              cnt    <= CW'(DW_N - 1);
              busy   <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          prem   <= step_rem;
          quo_sr <= {quo_sr[DW_N-2:0], step_q};
          dvd_sr <= {dvd_sr[DW_N-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            // Last step: publish directly from the step outputs.
            quotient    <= {quo_sr[DW_N-2:0], step_q};
            remainder   <= step_rem[DW_D-1:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div8x4.sv
// Testbench for seq_div8x4: table of directed divisions, hand-written
// sequences for held start and mid-run reset, and an exhaustive sweep
// against a reference model. Results are checked by a scoreboard queue.
module tb_seq_div8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  seq_div8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_seen = 0;
  int   done_expected = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  // Issue one division in the current (idle) cycle, wait for done, check
  // latency, and return in the idle cycle following DONE.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] q, input logic [3:0] r,
                         input logic dbz, input int exp_lat, input bit check_each);
    exp_t e;
    int lat;
    e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    done_expected++;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 1;
    if (check_each) chk("busy_after_accept", busy, (b != 0));
    while (done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1'b1);
    if (check_each || lat != exp_lat) chk("latency", lat, exp_lat);
    if (check_each) chk("busy_at_done", busy, 1'b0);
    @(posedge clk); #1;
    if (check_each) chk("done_single_pulse", done, 1'b0);
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int seen_before;

    vecs[0] = '{dvd: 200, dvs: 7,  q: 28,    r: 4, dbz: 0, lat: 9};
    vecs[1] = '{dvd: 255, dvs: 15, q: 17,    r: 0, dbz: 0, lat: 9};
    vecs[2] = '{dvd: 5,   dvs: 9,  q: 0,     r: 5, dbz: 0, lat: 9};
    vecs[3] = '{dvd: 100, dvs: 0,  q: 8'hFF, r: 0, dbz: 1, lat: 1};
    vecs[4] = '{dvd: 100, dvs: 3,  q: 33,    r: 1, dbz: 0, lat: 9};
    vecs[5] = '{dvd: 0,   dvs: 5,  q: 0,     r: 0, dbz: 0, lat: 9};
    vecs[6] = '{dvd: 255, dvs: 1,  q: 255,   r: 0, dbz: 0, lat: 9};
    vecs[7] = '{dvd: 1,   dvs: 15, q: 0,     r: 1, dbz: 0, lat: 9};
    vecs[8] = '{dvd: 128, dvs: 8,  q: 16,    r: 0, dbz: 0, lat: 9};
    vecs[9] = '{dvd: 254, dvs: 13, q: 19,    r: 7, dbz: 0, lat: 9};

    // Reset with start held high: must be ignored.
    rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);

    // Directed table, issued back-to-back; first start is in the first
    // cycle after reset release.
    for (int i = 0; i < 10; i++)
      run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, 1'b1);

    // start held high through RUN with operands changing: only 77/6 counts.
    sb.push_back('{q: 8'd12, r: 4'd5, dbz: 1'b0});
    done_expected++;
    dividend = 8'd77; divisor = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      dividend = 8'($urandom);
      divisor  = 4'($urandom_range(1, 15));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("held_start_latency", lat, 9);
    repeat (12) @(posedge clk);
    #1;
    chk("held_start_done_count", done_seen, done_expected);

    // Reset during RUN cycle 4: no done, outputs cleared.
    dividend = 8'd50; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_abort", busy, 1);
    seen_before = done_seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen, seen_before);
    run_div(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 9, 1'b1);

    // Exhaustive sweep against the reference model.
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        run_div(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_done_count", done_seen, done_expected);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
